// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write bypass, hard-wired zero
// register and a sequential soft-clear sweep with busy/done handshake.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         wr_ready,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         clr_done
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic                wr_acc;
    logic                wr_keep;

    assign wr_ready = (state == IDLE);
    assign clr_busy = (state == CLEAR);

    // Bypass is gated by reset so all read ports show zero while rst is low.
    assign wr_acc  = wr_en && wr_ready && rst;
    assign wr_keep = !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state    <= IDLE;
            ptr      <= FIRST;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A write and a clear request in the same cycle both take
                    // effect; the sweep later zeroes the written register.
                    if (wr_en && wr_keep) begin
                        regs[wr_addr] <= wr_data;
                    end
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= FIRST;
                    end
                end
                CLEAR: begin
                    regs[ptr] <= '0;
                    if (ptr == LAST) begin
                        state    <= IDLE;
                        ptr      <= FIRST;
                        clr_done <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              is_zero;
            logic              hit;

            assign ra      = rd_addr[gi*ADDR_W +: ADDR_W];
            assign is_zero = (ZERO_REG != 0) && (ra == '0);
            assign hit     = (BYPASS != 0) && wr_acc && (ra == wr_addr);
            assign rd_data[gi*DATA_W +: DATA_W] = is_zero ? '0 :
                                                  hit     ? wr_data :
                                                            regs[ra];
        end
    endgenerate

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the mips32 datapath, the generalised successor to the fixed 32x32 two-read-port bank. Width, depth and read-port count are parameters. It adds optional write-to-read bypass, an optional hard-wired zero register, and a sequential soft-clear engine with busy/done handshake. It sits between decode (read ports) and write-back (write port) and lets the pipeline clear architectural state without asserting global reset.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_READ, 2, number of independent combinational read ports (1..8)
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary storage
- BYPASS, 1, 1: a write accepted this cycle is forwarded to same-address reads; 0: reads see stored value only
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_READ*ADDR_W  read addresses; port k = [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_READ*DATA_W  read data; port k = [k*DATA_W +: DATA_W]
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  write accepted when wr_en && wr_ready at rising edge
- clr_req  in  1  soft-clear request, sampled in IDLE
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse, clear completed

## Operation
- Storage: DEPTH x DATA_W registers (DEPTH-1 when ZERO_REG=1). Reads are combinational, with no port conflicts and every port independent.
- Write: on an accepted write, regs[wr_addr] <= wr_data at the rising edge. When ZERO_REG=1 and wr_addr==0, the write is accepted but dropped.
- Bypass (BYPASS=1): when a write is accepted this cycle and rd_addr[k]==wr_addr, with the address nonzero or ZERO_REG=0, rd_data[k]=wr_data. Otherwise rd_data[k]=regs[rd_addr[k]].
- ZERO_REG=1: rd_addr[k]==0 gives 0 regardless of bypass.
- FSM states: IDLE, CLEAR.
  - IDLE: wr_ready=1. When clr_req=1 at the edge, go to CLEAR with ptr <= FIRST (FIRST = ZERO_REG ? 1 : 0).
  - CLEAR: wr_ready=0 and clr_busy=1. Each edge does regs[ptr] <= 0 and ptr <= ptr+1. The edge that clears DEPTH-1 returns to IDLE and sets clr_done <= 1.
  - clr_done clears on the next edge.
- clr_req while in CLEAR: ignored, with no queueing.
- clr_req and an accepted write in the same IDLE cycle: the write commits, then the sweep zeroes that register anyway.
- Reads during CLEAR: registers below ptr return 0. The register at ptr returns its old value until the edge. Bypass is inactive because no writes are accepted.
- wr_en while wr_ready=0: no effect. The requester holds the request and retries.
- Reset (rst=0, asynchronous): all registers 0, state IDLE, ptr=FIRST.
- Output values during and after reset: clr_busy=0, clr_done=0, wr_ready=1, all rd_data=0.
- ptr is ADDR_W bits wide. The sweep ends on ptr==DEPTH-1 and never wraps.

## Timing
- Write latency: visible via bypass in the same cycle, and from storage in the cycle after the edge.
- Clear duration: clr_busy is high for exactly DEPTH-FIRST cycles, starting the cycle after clr_req is sampled. Default parameters give 31 cycles.
- clr_done is high for exactly one cycle, immediately after clr_busy falls. wr_ready returns to 1 in that same cycle.
- Back-to-back clear: clr_req held high is sampled again in the clr_done cycle (IDLE) and starts a new sweep the next cycle.
- Reset mid-sweep: the FSM aborts immediately, storage is zeroed and there is no clr_done pulse.

## Test plan
- Reset then read: after rst is released, write 0x1234_5678 to r5 and read it on ports 0 and 1 the next cycle. Both ports return 0x12345678. r0 returns 0.
- Bypass: same-cycle write of 0xDEAD_BEEF to r7 with rd_addr[0]=7. rd_data[0]=0xDEADBEEF that cycle with BYPASS=1, and the old value with BYPASS=0.
- Zero register: write 0xFFFF_FFFF to r0 with ZERO_REG=1, so reads give 0. Repeat with ZERO_REG=0, so reads give 0xFFFFFFFF.
- Soft clear, default parameters:
  - Stimulus: fill r1..r31 with i*3, then pulse clr_req.
  - clr_busy is high for 31 cycles and wr_ready is low during that window.
  - A write to r9 mid-sweep is dropped.
  - clr_done pulses once, then all reads return 0.
- Reset mid-sweep: assert rst at sweep cycle 10. clr_busy drops asynchronously, clr_done never pulses, and all registers read 0.
- Parametric: DATA_W=16, ADDR_W=3, NUM_READ=4. Write distinct values to r1..r7 and read all four ports at once with different addresses. Each port returns its value, and a clear takes 7 cycles.
